// File: rtl/gvizi_pkg.sv
// gvizi_pkg: shared state encoding and default sizes for the per-channel delay timer
package gvizi_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} dly_state_t;
    localparam int N_CH_DEF = 4;
    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/delay_ch_slot.sv
// delay_ch_slot: one channel's shadow delay, enable and sticky fired flag
module delay_ch_slot
    import gvizi_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_delay,
    input  logic             i_en,
    output logic             o_fired,
    output logic             o_done_ok
);
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic en_q, en_d, fired_q, fired_d, hit;
    assign hit = i_run & en_q & (i_cnt == shadow_q);
    assign o_done_ok = fired_q | hit | ~en_q;
    assign o_fired = fired_q;
    always_comb begin
        shadow_d = i_load ? i_delay : shadow_q;
        en_d = i_load ? i_en : en_q;
        // Disabled channels park high so upstream never discharges them
        fired_d = (i_load | i_clear) ? ~i_en : (fired_q | hit);
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shadow_q <= '0;
            en_q <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            en_q <= en_d;
            fired_q <= fired_d;
        end
    end
endmodule

// File: rtl/delay_ch_counter.sv
// delay_ch_counter: shared up-counter ending each channel's discharge after its programmed delay
module delay_ch_counter
    import gvizi_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_startcounter,
    input  logic [N_CH*CNT_W-1:0] i_delay,
    input  logic [N_CH-1:0]       i_ch_en,
    output logic [N_CH-1:0]       o_reset_ch,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_abort,
    output logic [CNT_W-1:0]      o_count
);
    dly_state_t state_q, state_d;
    logic start_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic done_q, done_d, abort_q, abort_d;
    logic exit, load, clear, run;
    logic [N_CH-1:0] done_ok;
    assign exit = (state_q != ST_IDLE) & ~i_startcounter;
    assign load = (state_q == ST_IDLE) & i_startcounter & ~start_q;
    assign clear = (state_q == ST_IDLE) | exit;
    assign run = (state_q == ST_RUN) & i_startcounter;
    assign abort_d = (state_q == ST_RUN) & ~i_startcounter;
    assign done_d = run & (&done_ok);
    always_comb begin
        state_d = exit ? ST_IDLE : load ? ST_RUN : done_d ? ST_DONE : state_q;
        // Compare uses the pre-increment value, so an all-ones delay still fires
        cnt_d = (load | abort_d) ? '0 : (run & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            cnt_q <= '0;
            done_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= i_startcounter;
            cnt_q <= cnt_d;
            done_q <= done_d;
            abort_q <= abort_d;
        end
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        delay_ch_slot #(.CNT_W(CNT_W)) u_slot (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_load   (load),
            .i_clear  (clear),
            .i_run    (run),
            .i_cnt    (cnt_q),
            .i_delay  (i_delay[i*CNT_W +: CNT_W]),
            .i_en     (i_ch_en[i]),
            .o_fired  (o_reset_ch[i]),
            .o_done_ok(done_ok[i])
        );
    end
    assign o_busy = (state_q == ST_RUN);
    assign o_done = done_q;
    assign o_abort = abort_q;
    assign o_count = cnt_q;
endmodule
